// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver: synchronises rx, detects the start bit,
// samples each data and stop bit at mid-bit, and flags bad stop bits.
module uart_rx_os #(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 frame_err
);

    localparam int TICK_W = $clog2(OS_RATE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OS_RATE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OS_RATE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                r_state;
    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  r_rx_data;
    logic                  r_rx_done;
    logic                  r_frame_err;

    // NOTE: synchroniser flops reset to 1 (idle line) so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                    end
                end
                S_START: begin
                    if (b_tick) begin
                        // Re-check the line at mid start bit to reject glitches.
                        if (r_tick_cnt == TICK_MID) begin
                            if (!r_rx_s) begin
                                r_state    <= S_DATA;
                                r_tick_cnt <= '0;
                                r_bit_cnt  <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (b_tick) begin
                        if (r_tick_cnt == TICK_LAST) begin
                            r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                            r_tick_cnt <= '0;
                            if (r_bit_cnt == BIT_LAST) begin
                                r_state <= S_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (b_tick) begin
                        // Leave at mid stop bit so a back-to-back start edge is not missed.
                        if (r_tick_cnt == TICK_LAST) begin
                            r_rx_data   <= r_shift;
                            r_frame_err <= ~r_rx_s;
                            r_rx_done   <= 1'b1;
                            r_state     <= S_IDLE;
                            r_tick_cnt  <= '0;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: b_tick every 4 clk, so one bit is 64 clk.
module tb_uart_rx_os;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       rst;
    logic       b_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    int         total;
    int         bad;
    int         done_cnt;
    int         done_in_rst;
    logic [7:0] q_data[$];
    logic       q_ferr[$];

    uart_rx_os #(.DATA_BITS(8), .OS_RATE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .b_tick    (b_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        b_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            b_tick = 1'b1;
            @(negedge clk);
            b_tick = 1'b0;
        end
    end

    // Every cycle with rx_done high is counted, so a stretched pulse shows up as extra frames.
    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt = done_cnt + 1;
            q_data.push_back(rx_data);
            q_ferr.push_back(frame_err);
            if (rst) done_in_rst = done_in_rst + 1;
        end
    end

    task automatic drive_bit(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_head(input logic [7:0] d);
        drive_bit(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_head(d);
        drive_bit(1'b1, BIT_CLKS);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", rx_data); end
        total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", rx_done); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", rx_busy); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy: got %b want 0", rx_busy); end
    endtask

    task automatic test_loopback;
        int n0;
        n0 = done_cnt;
        send_head(8'hA5);
        drive_bit(1'b1, 16);
        total++; if (done_cnt !== n0) begin bad++; $display("FAIL t1_early_done: got %0d want %0d", done_cnt, n0); end
        drive_bit(1'b1, 48);
        repeat (16) @(negedge clk);
        total++; if (done_cnt !== n0 + 1) begin bad++; $display("FAIL t1_done_cnt: got %0d want %0d", done_cnt, n0 + 1); end
        total++; if (q_data[n0] !== 8'hA5) begin bad++; $display("FAIL t1_pulse_data: got %h want a5", q_data[n0]); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL t1_data: got %h want a5", rx_data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL t1_ferr: got %b want 0", frame_err); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL t1_busy: got %b want 0", rx_busy); end
    endtask

    task automatic test_glitch;
        int n0;
        n0 = done_cnt;
        drive_bit(1'b0, 16);
        total++; if (rx_busy !== 1'b1) begin bad++; $display("FAIL t2_busy_start: got %b want 1", rx_busy); end
        drive_bit(1'b1, 48);
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL t2_busy_after: got %b want 0", rx_busy); end
        total++; if (done_cnt !== n0) begin bad++; $display("FAIL t2_done_cnt: got %0d want %0d", done_cnt, n0); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL t2_data: got %h want a5", rx_data); end
    endtask

    task automatic test_framing;
        int n0;
        n0 = done_cnt;
        send_head(8'h3C);
        // Stop bit low only past its middle, so the tail is rejected as a glitch.
        drive_bit(1'b0, 40);
        drive_bit(1'b1, 24);
        repeat (BIT_CLKS) @(negedge clk);
        total++; if (done_cnt !== n0 + 1) begin bad++; $display("FAIL t3_done_cnt1: got %0d want %0d", done_cnt, n0 + 1); end
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL t3_data1: got %h want 3c", rx_data); end
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL t3_ferr1: got %b want 1", frame_err); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL t3_busy: got %b want 0", rx_busy); end
        send_frame(8'h81);
        repeat (16) @(negedge clk);
        total++; if (done_cnt !== n0 + 2) begin bad++; $display("FAIL t3_done_cnt2: got %0d want %0d", done_cnt, n0 + 2); end
        total++; if (rx_data !== 8'h81) begin bad++; $display("FAIL t3_data2: got %h want 81", rx_data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL t3_ferr2: got %b want 0", frame_err); end
    endtask

    task automatic test_back_to_back;
        int n0;
        logic [7:0] exp [3];
        exp[0] = 8'h00;
        exp[1] = 8'hFF;
        exp[2] = 8'h55;
        n0 = done_cnt;
        for (int k = 0; k < 3; k++) send_frame(exp[k]);
        repeat (16) @(negedge clk);
        total++; if (done_cnt !== n0 + 3) begin bad++; $display("FAIL t4_done_cnt: got %0d want %0d", done_cnt, n0 + 3); end
        for (int k = 0; k < 3; k++) begin
            total++; if (q_data[n0 + k] !== exp[k]) begin bad++; $display("FAIL t4_data%0d: got %h want %h", k, q_data[n0 + k], exp[k]); end
            total++; if (q_ferr[n0 + k] !== 1'b0) begin bad++; $display("FAIL t4_ferr%0d: got %b want 0", k, q_ferr[n0 + k]); end
        end
    endtask

    task automatic test_reset_mid_frame;
        int n0;
        n0 = done_cnt;
        // Start bit and first bits of 0x12 (LSB first: 0,1,0,...), then reset mid DATA.
        drive_bit(1'b0, BIT_CLKS);
        drive_bit(1'b0, BIT_CLKS);
        drive_bit(1'b1, BIT_CLKS);
        drive_bit(1'b0, 20);
        #2 rst = 1'b1;
        #20;
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL t5_rst_data: got %h want 00", rx_data); end
        total++; if (rx_done !== 1'b0) begin bad++; $display("FAIL t5_rst_done: got %b want 0", rx_done); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL t5_rst_busy: got %b want 0", rx_busy); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL t5_rst_ferr: got %b want 0", frame_err); end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (32) @(negedge clk);
        total++; if (done_cnt !== n0) begin bad++; $display("FAIL t5_no_done: got %0d want %0d", done_cnt, n0); end
        total++; if (rx_busy !== 1'b0) begin bad++; $display("FAIL t5_busy: got %b want 0", rx_busy); end
        send_frame(8'h6E);
        repeat (16) @(negedge clk);
        total++; if (done_cnt !== n0 + 1) begin bad++; $display("FAIL t5_done_cnt: got %0d want %0d", done_cnt, n0 + 1); end
        total++; if (rx_data !== 8'h6E) begin bad++; $display("FAIL t5_data: got %h want 6e", rx_data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL t5_ferr: got %b want 0", frame_err); end
        total++; if (done_in_rst !== 0) begin bad++; $display("FAIL t5_done_in_rst: got %0d want 0", done_in_rst); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        done_cnt    = 0;
        done_in_rst = 0;
        rst         = 1'b1;
        rx          = 1'b1;
        test_reset();
        test_loopback();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
